// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared glyph constants and segment bit order for the hex display driver
package seg_pkg;

  // Segment vector layout: bit 6 is segment a, bit 0 is segment g, all active-low.
  typedef logic [6:0] seg_t;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
  } seg_bits_t;

  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  // All segments dark.
  localparam seg_t SEG_OFF = 7'h7F;

  // Standard hex glyphs, active-low {a,b,c,d,e,f,g}.
  localparam seg_t GLYPH_0 = 7'b0000001;
  localparam seg_t GLYPH_1 = 7'b1001111;
  localparam seg_t GLYPH_2 = 7'b0010010;
  localparam seg_t GLYPH_3 = 7'b0000110;
  localparam seg_t GLYPH_4 = 7'b1001100;
  localparam seg_t GLYPH_5 = 7'b0100100;
  localparam seg_t GLYPH_6 = 7'b0100000;
  localparam seg_t GLYPH_7 = 7'b0001111;
  localparam seg_t GLYPH_8 = 7'b0000000;
  localparam seg_t GLYPH_9 = 7'b0000100;
  localparam seg_t GLYPH_A = 7'b0001000;
  localparam seg_t GLYPH_B = 7'b1100000;
  localparam seg_t GLYPH_C = 7'b0110001;
  localparam seg_t GLYPH_D = 7'b1000010;
  localparam seg_t GLYPH_E = 7'b0110000;
  localparam seg_t GLYPH_F = 7'b0111000;

  function automatic seg_t hex_glyph(input logic [3:0] nib);
    seg_t g;
    case (nib)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// rtl/seg_scan_display_if.sv - load/display signal bundle between a status source and the scan driver
interface seg_scan_display_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;
  logic                  pending;

  modport master (
    output enable, load, value, dp_in,
    input  seg, dp, an, frame_done, pending
  );

  modport slave (
    input  enable, load, value, dp_in,
    output seg, dp, an, frame_done, pending
  );
endinterface

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - nibble to active-low seven-segment glyph with blanking
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output seg_t       glyph
);

  // Look up the glyph, forcing all segments dark when blanked.
  always_comb begin
    glyph = hex_glyph(nibble);
    if (blank) glyph = SEG_OFF;
  end

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - time-multiplexed hex display driver, optional SEG_LZB_EN leading-zero blanking
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_display_if.slave  bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [PW-1:0]        pcnt;
  logic [IW-1:0]        idx;
  logic                 tc;
  logic                 wrap;

  logic [4*DIGITS-1:0]  shadow_val;
  logic [DIGITS-1:0]    shadow_dp;
  logic [4*DIGITS-1:0]  disp_val;
  logic [DIGITS-1:0]    disp_dp;
  logic                 pending_q;

  logic [3:0]           nib_sel;
  logic                 dp_sel;
  logic                 blank_sel;
  logic [DIGITS-1:0]    blank_vec;
  logic [DIGITS-1:0]    an_nxt;
  seg_t                 glyph;

  seg_t                 seg_q;
  logic                 dp_q;
  logic [DIGITS-1:0]    an_q;
  logic                 frame_done_q;

  // A slot ends on the prescaler's last count; the frame ends when the last digit's slot ends.
  assign tc   = bus.enable && (pcnt == PCNT_LAST);
  assign wrap = tc && (idx == IDX_LAST);

  // Prescaler and digit index advance only while scanning is enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (bus.enable) begin
      if (tc) begin
        pcnt <= '0;
        idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  // Shadow captures loads; display takes the shadow only at a frame boundary so no frame is torn.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pending_q  <= 1'b0;
    end else if (wrap && bus.load) begin
      shadow_val <= bus.value;
      shadow_dp  <= bus.dp_in;
      disp_val   <= bus.value;
      disp_dp    <= bus.dp_in;
      pending_q  <= 1'b0;
    end else begin
      if (bus.load) begin
        shadow_val <= bus.value;
        shadow_dp  <= bus.dp_in;
        pending_q  <= 1'b1;
      end
      if (wrap && pending_q) begin
        disp_val  <= shadow_val;
        disp_dp   <= shadow_dp;
        pending_q <= 1'b0;
      end
    end
  end

`ifdef SEG_LZB_EN
  logic zero_run;

  // A digit above 0 is blanked when it and every digit above it hold zero.
  always_comb begin
    blank_vec = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run     = zero_run && (disp_val[4*i +: 4] == 4'h0);
      blank_vec[i] = zero_run;
    end
  end
`else
  assign blank_vec = '0;
`endif

  // Select the current digit's nibble, dp and blank, and build the one-cold digit enable.
  always_comb begin
    nib_sel   = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    an_nxt    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib_sel   = disp_val[4*i +: 4];
        dp_sel    = disp_dp[i];
        blank_sel = blank_vec[i];
        an_nxt[i] = 1'b0;
      end
    end
  end

  seg_hex_decode u_decode (
    .nibble (nib_sel),
    .blank  (blank_sel),
    .glyph  (glyph)
  );

  // Register all display outputs; everything goes dark while scanning is disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= wrap;
      if (bus.enable) begin
        seg_q <= glyph;
        dp_q  <= ~dp_sel;
        an_q  <= an_nxt;
      end else begin
        seg_q <= SEG_OFF;
        dp_q  <= 1'b1;
        an_q  <= '1;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - scoreboard bench for seg_scan_display, DIGITS=4 SCAN_DIV=4
module tb_seg_scan_display;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic exp_pending = 1'b0;
  exp_t sb[$];

  logic [6:0] glyph_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  seg_scan_display_if #(.DIGITS(4)) bus ();

  seg_scan_display #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_frame(input logic [15:0] v, input logic [3:0] d);
    exp_t       e;
    logic [3:0] blk;
    logic [3:0] nib;
    blk = 4'b0000;
`ifdef SEG_LZB_EN
    begin
      logic zr;
      zr = 1'b1;
      for (int i = 3; i > 0; i--) begin
        nib    = v[4*i +: 4];
        zr     = zr && (nib == 4'h0);
        blk[i] = zr;
      end
    end
`endif
    for (int i = 0; i < 4; i++) begin
      nib   = v[4*i +: 4];
      e.an  = ~(4'b0001 << i);
      e.seg = blk[i] ? 7'h7F : glyph_tab[nib];
      e.dp  = ~d[i];
      sb.push_back(e);
    end
  endfunction

  task automatic wait_fd(input string tag);
    int n = 0;
    while (bus.frame_done !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, bus.frame_done}, 32'd1);
  endtask

  task automatic run_frame(input string tag, input int load_at, input logic [15:0] lval,
                           input logic [3:0] ldp);
    exp_t e;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == load_at) begin
        bus.value = lval;
        bus.dp_in = ldp;
        bus.load  = 1'b1;
        push_frame(lval, ldp);
        if (c < 15) exp_pending = 1'b1;
      end
      @(negedge clk);
      bus.load = 1'b0;
      if (c == 15) exp_pending = 1'b0;
      if (c % 4 == 0) begin
        if (sb.size() == 0) chk($sformatf("%s_c%0d_sb_empty", tag, c), 32'd0, 32'd1);
        else e = sb.pop_front();
      end
      chk($sformatf("%s_c%0d_an", tag, c), {28'b0, bus.an}, {28'b0, e.an});
      chk($sformatf("%s_c%0d_seg", tag, c), {25'b0, bus.seg}, {25'b0, e.seg});
      chk($sformatf("%s_c%0d_dp", tag, c), {31'b0, bus.dp}, {31'b0, e.dp});
      chk($sformatf("%s_c%0d_fd", tag, c), {31'b0, bus.frame_done}, (c == 15) ? 32'd1 : 32'd0);
      chk($sformatf("%s_c%0d_pend", tag, c), {31'b0, bus.pending}, {31'b0, exp_pending});
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    bus.load   = 1'b0;
    bus.value  = '0;
    bus.dp_in  = '0;

    // reset held for three clocks
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_seg", {25'b0, bus.seg}, 32'h7F);
    chk("rst_an", {28'b0, bus.an}, 32'hF);
    chk("rst_dp", {31'b0, bus.dp}, 32'd1);
    chk("rst_fd", {31'b0, bus.frame_done}, 32'd0);
    chk("rst_pend", {31'b0, bus.pending}, 32'd0);

    // release: digit 0 lights on the next cycle showing a zero
    rst_n      = 1'b1;
    bus.enable = 1'b1;
    @(negedge clk);
    chk("rel_an", {28'b0, bus.an}, 32'hE);
    chk("rel_seg", {25'b0, bus.seg}, 32'h01);

    // load 8F10, committed at the first frame boundary
    bus.value = 16'h8F10;
    bus.dp_in = 4'b0000;
    bus.load  = 1'b1;
    push_frame(16'h8F10, 4'b0000);
    @(negedge clk);
    bus.load = 1'b0;
    chk("scan_pend_set", {31'b0, bus.pending}, 32'd1);
    wait_fd("scan_fd_wait");
    chk("scan_pend_clr", {31'b0, bus.pending}, 32'd0);

    // show 8F10 while loading 1234 mid-frame
    run_frame("scan", 5, 16'h1234, 4'b0000);
    // show 1234 while loading AAAA coincident with the boundary
    run_frame("tear", 15, 16'hAAAA, 4'b0000);
    // AAAA straight away, no pending
    run_frame("coinc", -1, 16'h0000, 4'b0000);

    // disable for 10 cycles two cycles into digit 1's slot
    repeat (6) @(negedge clk);
    chk("en_pre_an", {28'b0, bus.an}, 32'hD);
    bus.enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("en_off%0d_an", k), {28'b0, bus.an}, 32'hF);
      chk($sformatf("en_off%0d_seg", k), {25'b0, bus.seg}, 32'h7F);
      chk($sformatf("en_off%0d_dp", k), {31'b0, bus.dp}, 32'd1);
    end
    bus.enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("en_rem%0d_an", k), {28'b0, bus.an}, 32'hD);
      chk($sformatf("en_rem%0d_seg", k), {25'b0, bus.seg}, 32'h08);
    end
    @(negedge clk);
    chk("en_next_an", {28'b0, bus.an}, 32'hB);

    // leading zeros with a decimal point on digit 2
    bus.value = 16'h0005;
    bus.dp_in = 4'b0100;
    bus.load  = 1'b1;
    push_frame(16'h0005, 4'b0100);
    @(negedge clk);
    bus.load = 1'b0;
    chk("lzb_pend_set", {31'b0, bus.pending}, 32'd1);
    wait_fd("lzb_fd_wait");
    chk("lzb_pend_clr", {31'b0, bus.pending}, 32'd0);
    run_frame("lzb", -1, 16'h0000, 4'b0000);

    // reset mid-frame discards a pending load and clears the display
    repeat (3) @(negedge clk);
    bus.value = 16'h9999;
    bus.dp_in = 4'b1111;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("mrst_pend_set", {31'b0, bus.pending}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_seg", {25'b0, bus.seg}, 32'h7F);
    chk("mrst_an", {28'b0, bus.an}, 32'hF);
    chk("mrst_pend", {31'b0, bus.pending}, 32'd0);
    chk("mrst_fd", {31'b0, bus.frame_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_rel_an", {28'b0, bus.an}, 32'hE);
    chk("mrst_rel_seg", {25'b0, bus.seg}, 32'h01);
    chk("mrst_rel_dp", {31'b0, bus.dp}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
